trace_expander: RTL and testbench
=================================

Name: trace_expander

Overview:
- Receive-side counterpart of the trace filter in the continuous monitoring system.
- Consumes filtered trace packets. Each packet holds one kept (resync) instruction, its PC, and the number of instructions dropped immediately before it.
- Re-expands each packet into a per-instruction timeline for the host-side analysis path: one beat per dropped slot, then the kept beat.
- Also flags any gap longer than the filter's resync period, which a correct filter cannot produce.

Parameters:
- PC_WIDTH, 64, width of program counter fields.
- INSTR_WIDTH, RISC_V_INSTRUCTION_WIDTH, width of instruction fields.
- GAP_WIDTH, RESYNC_TIMER_WIDTH, width of the dropped-instruction count.
- MAX_GAP, RESYNC_TIMER_RESET_VALUE, largest legal dropped count.
- COUNT_WIDTH, 32, width of the emitted-beat counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  input packet valid
- in_ready  out  1  input packet accepted when in_valid && in_ready
- in_pc  in  PC_WIDTH  PC of kept instruction
- in_instr  in  INSTR_WIDTH  kept instruction word
- in_drop_count  in  GAP_WIDTH  instructions dropped before this one
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_pc  out  PC_WIDTH  PC of beat; 0 on gap beats
- out_instr  out  INSTR_WIDTH  instruction of beat; 0 on gap beats
- out_pc_valid  out  1  1 on the kept beat, 0 on gap beats
- out_is_resync  out  1  equals out_pc_valid (kept beats are resync points)
- beat_count  out  COUNT_WIDTH  total output handshakes, wraps modulo 2^COUNT_WIDTH
- gap_overflow  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all outputs 0; internal registers 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-packet discards the packet and its remaining gap beats; no partial resume.
- States (trace_expander_state_t): IDLE, GAP, KEPT.
- in_ready = (state==IDLE) || (state==KEPT && out_ready). This is combinational from out_ready and allows back-to-back packets with no bubble.
- Accept (handshake in cycle N):
  - Register pc, instr and drop_count.
  - Set remaining = drop_count.
  - Next state is GAP if drop_count != 0, else KEPT.
  - The first output beat is valid in cycle N+1 (latency 1).
- GAP:
  - Outputs: out_valid=1, out_pc_valid=0, out_pc=0, out_instr=0.
  - On out_ready: remaining decrements; if remaining==1, next state is KEPT.
- KEPT:
  - Outputs: out_valid=1, out_pc_valid=1, out_is_resync=1; out_pc and out_instr come from the registered packet.
  - On out_ready with a simultaneous input handshake: load the new packet as on accept. No IDLE cycle.
  - On out_ready with no input handshake: go to IDLE.
- IDLE: out_valid=0.
- Output stability: outputs hold stable while out_valid && !out_ready (AXI-stream rule).
- beat_count increments on every out_valid && out_ready. Wraps from all-ones to 0.
- gap_overflow:
  - Set in the cycle after accepting a packet with in_drop_count > MAX_GAP.
  - Stays set until reset.
  - The packet is still fully expanded; the flag does not block the stream.
- in_drop_count == 0 gives exactly one beat, the kept beat.
- A gap of 2^GAP_WIDTH-1 must expand fully: no counter truncation and no early exit.
- Widths: remaining is GAP_WIDTH bits; the comparison against MAX_GAP is unsigned.

Decomposition:
- Shared package continuous_monitoring_system_pkg:
  - Add trace_expander_state_t (enum IDLE/GAP/KEPT).
  - Add TRACE_PC_WIDTH = 64.
  - Reuse the existing RESYNC_TIMER_WIDTH, RESYNC_TIMER_RESET_VALUE and RISC_V_INSTRUCTION_WIDTH.
- No sub-module required. The FSM, the gap counter and the output register form a single module.

Test Plan:
- Single packet: pc=0x8000_0000, instr=0x0000_0063, drop_count=3, out_ready=1. Expect 3 gap beats (pc_valid=0, pc=0), then the kept beat with pc=0x8000_0000 and is_resync=1. First beat one cycle after accept; beat_count=4.
- Back-to-back packets with drop_count=0, pc 0x100, 0x104, 0x108, in_valid held high, out_ready=1. Expect 3 consecutive kept beats with in_ready high throughout and no bubble cycle.
- Backpressure: drop_count=2, out_ready toggling 1,0,0,1,1. Beats hold stable while stalled; exactly 3 beats are delivered in order; in_ready stays 0 until the kept beat completes.
- Overflow: drop_count=MAX_GAP+1. gap_overflow=1 one cycle after accept and stays set; MAX_GAP+1 gap beats and 1 kept beat are still emitted. A following drop_count=MAX_GAP packet keeps the flag set.
- Reset mid-GAP: drop_count=5, assert rst_n=0 after 2 gap beats. Next cycle: out_valid=0, beat_count=0, gap_overflow=0, in_ready=1; no stale beats afterwards.
- Counter wrap: preload by streaming until beat_count = 2^COUNT_WIDTH-1 (short COUNT_WIDTH=4 build), then one more beat. Expect beat_count=0.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared types and widths for the continuous monitoring system
package continuous_monitoring_system_pkg;

    localparam int RISC_V_INSTRUCTION_WIDTH = 32;
    localparam int RESYNC_TIMER_WIDTH       = 8;
    localparam logic [RESYNC_TIMER_WIDTH-1:0] RESYNC_TIMER_RESET_VALUE = 8'd200;

    localparam int TRACE_PC_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        KEPT = 2'd2
    } trace_expander_state_t;

endpackage

// File: rtl/trace_expander.sv
// rtl/trace_expander.sv - re-expands filtered trace packets into a per-instruction beat stream
module trace_expander
    import continuous_monitoring_system_pkg::*;
#(
    parameter int PC_WIDTH    = TRACE_PC_WIDTH,
    parameter int INSTR_WIDTH = RISC_V_INSTRUCTION_WIDTH,
    parameter int GAP_WIDTH   = RESYNC_TIMER_WIDTH,
    parameter logic [GAP_WIDTH-1:0] MAX_GAP = GAP_WIDTH'(RESYNC_TIMER_RESET_VALUE),
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [GAP_WIDTH-1:0]   in_drop_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   out_pc_valid,
    output logic                   out_is_resync,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic                   gap_overflow
);

    trace_expander_state_t  state, state_d;
    logic [GAP_WIDTH-1:0]   remaining, remaining_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   in_fire;
    logic                   out_fire;

    assign in_ready = (state == IDLE) || (state == KEPT && out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        pc_d        = pc_q;
        instr_d     = instr_q;
        case (state)
            GAP: begin
                if (out_ready) begin
                    remaining_d = remaining - GAP_WIDTH'(1);
                    if (remaining == GAP_WIDTH'(1)) begin
                        state_d = KEPT;
                    end
                end
            end
            KEPT: begin
                if (out_ready && !in_fire) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        // A new packet can only be taken from IDLE or while the kept beat retires.
        if (in_fire) begin
            pc_d        = in_pc;
            instr_d     = in_instr;
            remaining_d = in_drop_count;
            state_d     = (in_drop_count != '0) ? GAP : KEPT;
        end
    end

    // Outputs are registered from the next-state view so they change only on beat retirement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            remaining     <= '0;
            pc_q          <= '0;
            instr_q       <= '0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_instr     <= '0;
            out_pc_valid  <= 1'b0;
            out_is_resync <= 1'b0;
            beat_count    <= '0;
            gap_overflow  <= 1'b0;
        end else begin
            state         <= state_d;
            remaining     <= remaining_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            out_valid     <= (state_d != IDLE);
            out_pc        <= (state_d == KEPT) ? pc_d : '0;
            out_instr     <= (state_d == KEPT) ? instr_d : '0;
            out_pc_valid  <= (state_d == KEPT);
            out_is_resync <= (state_d == KEPT);
            if (out_fire) begin
                beat_count <= beat_count + COUNT_WIDTH'(1);
            end
            if (in_fire && (in_drop_count > MAX_GAP)) begin
                gap_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_expander.sv
// tb/tb_trace_expander.sv - directed self-checking bench for trace_expander
module tb_trace_expander;
    import continuous_monitoring_system_pkg::*;

    localparam int PW = 64;
    localparam int IW = 32;
    localparam int GW = 8;
    localparam int CW = 4;
    localparam int MAXG = 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pc;
    logic [IW-1:0] in_instr;
    logic [GW-1:0] in_drop_count;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          out_pc_valid;
    logic          out_is_resync;
    logic [CW-1:0] beat_count;
    logic          gap_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_expander #(
        .PC_WIDTH(PW), .INSTR_WIDTH(IW), .GAP_WIDTH(GW),
        .MAX_GAP(8'(MAXG)), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_drop_count(in_drop_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_pc_valid(out_pc_valid), .out_is_resync(out_is_resync),
        .beat_count(beat_count), .gap_overflow(gap_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] pc, input logic [31:0] instr, input int drop);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_instr      = instr;
        in_drop_count = GW'(drop);
        check("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic gap_beats(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_gap_valid"}, out_valid, 1);
            check({tag, "_gap_pcv"}, out_pc_valid, 0);
            check({tag, "_gap_pc"}, out_pc, 0);
            check({tag, "_gap_ready"}, in_ready, 0);
            tick();
        end
    endtask

    task automatic kept_beat(input string tag, input logic [63:0] pc, input logic [31:0] instr);
        check({tag, "_kept_valid"}, out_valid, 1);
        check({tag, "_kept_pcv"}, out_pc_valid, 1);
        check({tag, "_kept_resync"}, out_is_resync, 1);
        check({tag, "_kept_pc"}, out_pc, pc);
        check({tag, "_kept_instr"}, out_instr, instr);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        in_drop_count = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_overflow", gap_overflow, 0);
        check("rst_pc", out_pc, 0);
        check("rst_in_ready", in_ready, 1);

        // single packet, drop 3
        out_ready = 1'b1;
        send(64'h8000_0000, 32'h0000_0063, 3);
        gap_beats("single", 3);
        kept_beat("single", 64'h8000_0000, 32'h0000_0063);
        check("single_idle", out_valid, 0);
        check("single_count", beat_count, 4);

        // back-to-back zero-gap packets, no bubble
        in_valid = 1'b1; in_drop_count = '0; in_instr = 32'h13;
        in_pc = 64'h100;
        check("b2b_ready0", in_ready, 1);
        tick();
        in_pc = 64'h104;
        check("b2b_ready1", in_ready, 1);
        check("b2b_pc0", out_pc, 64'h100);
        check("b2b_pcv0", out_pc_valid, 1);
        tick();
        in_pc = 64'h108;
        check("b2b_ready2", in_ready, 1);
        check("b2b_pc1", out_pc, 64'h104);
        tick();
        in_valid = 1'b0;
        check("b2b_pc2", out_pc, 64'h108);
        check("b2b_valid2", out_valid, 1);
        tick();
        check("b2b_idle", out_valid, 0);
        check("b2b_count", beat_count, 7);

        // backpressure, out_ready 1,0,0,1,1
        send(64'h200, 32'h0000_0013, 2);
        out_ready = 1'b1;
        check("bp_a_gap", out_pc_valid, 0);
        check("bp_a_ready", in_ready, 0);
        tick();
        out_ready = 1'b0;
        check("bp_b_valid", out_valid, 1);
        check("bp_b_gap", out_pc_valid, 0);
        check("bp_b_count", beat_count, 8);
        tick();
        check("bp_c_valid", out_valid, 1);
        check("bp_c_gap", out_pc_valid, 0);
        check("bp_c_pc", out_pc, 0);
        check("bp_c_count", beat_count, 8);
        check("bp_c_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        check("bp_d_gap", out_pc_valid, 0);
        check("bp_d_ready", in_ready, 0);
        tick();
        kept_beat("bp", 64'h200, 32'h0000_0013);
        check("bp_idle", out_valid, 0);
        check("bp_count", beat_count, 10);

        // overflow, then legal max, then full-range gap
        send(64'h300, 32'h0000_0033, MAXG + 1);
        check("ovf_set", gap_overflow, 1);
        gap_beats("ovf", MAXG + 1);
        kept_beat("ovf", 64'h300, 32'h0000_0033);
        check("ovf_count", beat_count, 4);
        send(64'h400, 32'h0000_0037, MAXG);
        gap_beats("max", MAXG);
        kept_beat("max", 64'h400, 32'h0000_0037);
        check("max_sticky", gap_overflow, 1);
        check("max_count", beat_count, 13);
        send(64'h500, 32'h0000_006f, 255);
        gap_beats("full", 255);
        kept_beat("full", 64'h500, 32'h0000_006f);
        check("full_idle", out_valid, 0);
        check("full_count", beat_count, 13);

        // reset in the middle of a gap
        send(64'h600, 32'h0000_0073, 5);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_count", beat_count, 0);
        check("mrst_overflow", gap_overflow, 0);
        check("mrst_ready", in_ready, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_no_stale", out_valid, 0);
        end
        check("mrst_count_hold", beat_count, 0);

        // beat counter wrap at 4 bits
        send(64'h700, 32'h0000_0003, 14);
        gap_beats("wrap", 14);
        kept_beat("wrap", 64'h700, 32'h0000_0003);
        check("wrap_pre", beat_count, 15);
        send(64'h704, 32'h0000_0007, 0);
        kept_beat("wrap1", 64'h704, 32'h0000_0007);
        check("wrap_zero", beat_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
